// File: rtl/demux_parametrizable.sv
// ----------------------------------------------------------------------------
// demux_parametrizable
//
// Registered demultiplexer / deserializer. Single words arriving on a
// valid/ready handshake are steered into one of `depth` lane registers,
// either by an explicit select (addressed mode) or by an auto-incrementing
// write pointer (sequential mode). When a frame is complete (every lane
// written, or a flush with at least one lane written) the whole lane array is
// presented in parallel on a frame-valid/frame-ready handshake.
//
// Ports
//   clk_i                clock, rising edge
//   rst_n_i              asynchronous active-low reset
//   demux_valid_i        input word valid
//   demux_ready_o        word accepted this cycle (high while filling)
//   demux_data_i         input word
//   demux_sel_i          target lane in addressed mode
//   demux_mode_i         0 = addressed, 1 = sequential (latched per frame)
//   demux_flush_i        close the current partial frame
//   demux_data_o         lane registers, unpacked [depth-1:0]
//   demux_wr_mask_o      bit n set = lane n written in the current frame
//   demux_frame_valid_o  frame complete, lanes stable
//   demux_frame_ready_i  consumer takes the frame
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | accepting words into lanes, ready high
// ST_FULL | frame presented, lanes/mask frozen until frame_ready
// ----------------------------------------------------------------------------
module demux_parametrizable #(
   parameter int depth = 16,
   parameter int bits  = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     demux_valid_i,
   output logic                     demux_ready_o,
   input  logic [bits-1:0]          demux_data_i,
   input  logic [$clog2(depth)-1:0] demux_sel_i,
   input  logic                     demux_mode_i,
   input  logic                     demux_flush_i,
   output logic [bits-1:0]          demux_data_o [depth-1:0],
   output logic [depth-1:0]         demux_wr_mask_o,
   output logic                     demux_frame_valid_o,
   input  logic                     demux_frame_ready_i
);

   localparam int SW = $clog2(depth);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_FULL = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [bits-1:0] lane_q [depth-1:0];
   logic [bits-1:0] lane_d [depth-1:0];
   logic [depth-1:0] mask_q, mask_d;
   logic [SW-1:0]   ptr_q, ptr_d;
   logic            mode_q, mode_d;

   logic            accept;
   logic            mode_eff;
   logic [SW-1:0]   lane_idx;
   logic [depth-1:0] lane_onehot;
   logic [depth-1:0] mask_upd;

   assign accept = demux_valid_i && (state_q == ST_FILL);

   // The mode only takes effect on the first word of a frame; after that the
   // latched copy steers the rest of the frame.
   assign mode_eff = (mask_q == '0) ? demux_mode_i : mode_q;
   assign lane_idx = mode_eff ? ptr_q : demux_sel_i;

   always_comb begin
      lane_onehot           = '0;
      lane_onehot[lane_idx] = 1'b1;
   end

   assign mask_upd = accept ? (mask_q | lane_onehot) : mask_q;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      mask_d  = mask_q;
      ptr_d   = ptr_q;
      mode_d  = mode_q;
      case (state_q)
         ST_FILL: begin
            if (accept) begin
               lane_d[lane_idx] = demux_data_i;
               mask_d           = mask_upd;
               if (mask_q == '0) mode_d = demux_mode_i;
               if (mode_eff)     ptr_d  = ptr_q + 1'b1;
            end
            // A flush in the same cycle as an accept includes that word.
            if ((&mask_upd) || (demux_flush_i && (mask_upd != '0))) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // Lane data is left stale on purpose; the mask qualifies it.
            if (demux_frame_ready_i) begin
               mask_d  = '0;
               ptr_d   = '0;
               state_d = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_FILL;
         mask_q  <= '0;
         ptr_q   <= '0;
         mode_q  <= 1'b0;
         for (int i = 0; i < depth; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         mode_q  <= mode_d;
         for (int i = 0; i < depth; i++) begin
            lane_q[i] <= lane_d[i];
         end
      end
   end

   assign demux_ready_o       = (state_q == ST_FILL);
   assign demux_frame_valid_o = (state_q == ST_FULL);
   assign demux_wr_mask_o     = mask_q;
   assign demux_data_o        = lane_q;

endmodule

// File: tb/tb_demux_parametrizable.sv
module tb_demux_parametrizable;

   localparam int depth = 16;
   localparam int bits  = 8;

   logic                     clk_i = 1'b0;
   logic                     rst_n_i;
   logic                     demux_valid_i;
   logic                     demux_ready_o;
   logic [bits-1:0]          demux_data_i;
   logic [$clog2(depth)-1:0] demux_sel_i;
   logic                     demux_mode_i;
   logic                     demux_flush_i;
   logic [bits-1:0]          demux_data_o [depth-1:0];
   logic [depth-1:0]         demux_wr_mask_o;
   logic                     demux_frame_valid_o;
   logic                     demux_frame_ready_i;

   int vectors     = 0;
   int miscompares = 0;

   demux_parametrizable #(.depth(depth), .bits(bits)) dut (
      .clk_i               (clk_i),
      .rst_n_i             (rst_n_i),
      .demux_valid_i       (demux_valid_i),
      .demux_ready_o       (demux_ready_o),
      .demux_data_i        (demux_data_i),
      .demux_sel_i         (demux_sel_i),
      .demux_mode_i        (demux_mode_i),
      .demux_flush_i       (demux_flush_i),
      .demux_data_o        (demux_data_o),
      .demux_wr_mask_o     (demux_wr_mask_o),
      .demux_frame_valid_o (demux_frame_valid_o),
      .demux_frame_ready_i (demux_frame_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n_i             = 1'b0;
      demux_valid_i       = 1'b0;
      demux_data_i        = '0;
      demux_sel_i         = '0;
      demux_mode_i        = 1'b0;
      demux_flush_i       = 1'b0;
      demux_frame_ready_i = 1'b0;

      // reset state
      #3;
      chk("rst_lane0", 16'(demux_data_o[0]), 16'h00);
      chk("rst_lane15", 16'(demux_data_o[15]), 16'h00);
      chk("rst_mask", demux_wr_mask_o, 16'h0000);
      chk("rst_ready", 16'(demux_ready_o), 16'h1);
      chk("rst_fvalid", 16'(demux_frame_valid_o), 16'h0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // sequential fill 0x00..0xFF
      demux_mode_i  = 1'b1;
      demux_valid_i = 1'b1;
      for (int i = 0; i < depth; i++) begin
         demux_data_i = 8'(i * 8'h11);
         @(negedge clk_i);
         if (i == depth - 2) begin
            chk("seq_fvalid_15", 16'(demux_frame_valid_o), 16'h0);
            chk("seq_mask_15", demux_wr_mask_o, 16'h7FFF);
         end
      end
      demux_valid_i = 1'b0;
      chk("seq_fvalid", 16'(demux_frame_valid_o), 16'h1);
      chk("seq_ready", 16'(demux_ready_o), 16'h0);
      chk("seq_mask", demux_wr_mask_o, 16'hFFFF);
      for (int i = 0; i < depth; i++) begin
         chk($sformatf("seq_lane%0d", i), 16'(demux_data_o[i]), 16'(8'(i * 8'h11)));
      end
      demux_frame_ready_i = 1'b1;
      @(negedge clk_i);
      demux_frame_ready_i = 1'b0;
      chk("seq_rel_ready", 16'(demux_ready_o), 16'h1);
      chk("seq_rel_fvalid", 16'(demux_frame_valid_o), 16'h0);
      chk("seq_rel_mask", demux_wr_mask_o, 16'h0000);

      // addressed with overwrite; mode flip mid-frame must be ignored
      demux_mode_i  = 1'b0;
      demux_valid_i = 1'b1;
      demux_sel_i   = 4'd3;
      demux_data_i  = 8'hA5;
      @(negedge clk_i);
      chk("adr_lane3_a", 16'(demux_data_o[3]), 16'hA5);
      chk("adr_mask_a", demux_wr_mask_o, 16'h0008);
      demux_mode_i  = 1'b1;
      demux_data_i  = 8'h5A;
      @(negedge clk_i);
      demux_sel_i   = 4'd7;
      demux_data_i  = 8'h3C;
      @(negedge clk_i);
      demux_valid_i = 1'b0;
      demux_flush_i = 1'b1;
      @(negedge clk_i);
      demux_flush_i = 1'b0;
      chk("adr_fvalid", 16'(demux_frame_valid_o), 16'h1);
      chk("adr_lane3", 16'(demux_data_o[3]), 16'h5A);
      chk("adr_lane7", 16'(demux_data_o[7]), 16'h3C);
      chk("adr_mask", demux_wr_mask_o, 16'h0088);
      chk("adr_stale5", 16'(demux_data_o[5]), 16'h55);
      chk("adr_lane0", 16'(demux_data_o[0]), 16'h00);
      demux_frame_ready_i = 1'b1;
      @(negedge clk_i);
      demux_frame_ready_i = 1'b0;

      // flush corners
      demux_flush_i = 1'b1;
      @(negedge clk_i);
      chk("fl0_ready", 16'(demux_ready_o), 16'h1);
      chk("fl0_fvalid", 16'(demux_frame_valid_o), 16'h0);
      chk("fl0_mask", demux_wr_mask_o, 16'h0000);
      demux_mode_i  = 1'b1;
      demux_valid_i = 1'b1;
      demux_data_i  = 8'h42;
      @(negedge clk_i);
      demux_flush_i = 1'b0;
      chk("fl1_fvalid", 16'(demux_frame_valid_o), 16'h1);
      chk("fl1_lane0", 16'(demux_data_o[0]), 16'h42);
      chk("fl1_mask", demux_wr_mask_o, 16'h0001);

      // backpressure in FULL
      demux_data_i = 8'h99;
      repeat (5) @(negedge clk_i);
      chk("bp_lane0", 16'(demux_data_o[0]), 16'h42);
      chk("bp_mask", demux_wr_mask_o, 16'h0001);
      chk("bp_ready", 16'(demux_ready_o), 16'h0);
      chk("bp_fvalid", 16'(demux_frame_valid_o), 16'h1);
      demux_frame_ready_i = 1'b1;
      @(negedge clk_i);
      demux_frame_ready_i = 1'b0;
      chk("bp_rel_ready", 16'(demux_ready_o), 16'h1);
      chk("bp_rel_mask", demux_wr_mask_o, 16'h0000);
      chk("bp_rel_lane0", 16'(demux_data_o[0]), 16'h42);
      @(negedge clk_i);
      chk("bp_acc_lane0", 16'(demux_data_o[0]), 16'h99);
      chk("bp_acc_mask", demux_wr_mask_o, 16'h0001);

      // four more sequential accepts (five in total), then async reset
      for (int i = 1; i < 5; i++) begin
         demux_data_i = 8'(i);
         @(negedge clk_i);
      end
      demux_valid_i = 1'b0;
      chk("mid_mask", demux_wr_mask_o, 16'h001F);
      chk("mid_lane4", 16'(demux_data_o[4]), 16'h04);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_lane0", 16'(demux_data_o[0]), 16'h00);
      chk("mid_rst_lane4", 16'(demux_data_o[4]), 16'h00);
      chk("mid_rst_mask", demux_wr_mask_o, 16'h0000);
      chk("mid_rst_ready", 16'(demux_ready_o), 16'h1);
      chk("mid_rst_fvalid", 16'(demux_frame_valid_o), 16'h0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      demux_mode_i  = 1'b1;
      demux_valid_i = 1'b1;
      demux_data_i  = 8'h77;
      @(negedge clk_i);
      demux_valid_i = 1'b0;
      chk("post_rst_lane0", 16'(demux_data_o[0]), 16'h77);
      chk("post_rst_mask", demux_wr_mask_o, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
